// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioning path.
// Holds the repeat FSM state encoding and the board clock tick divider.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      HELD_DELAY  = 2'd1,
      HELD_REPEAT = 2'd2
   } rep_state_e;

   // 1 ms sample period on the 27 MHz board clock
   localparam int TICK_DIV_27MHZ = 27000;

   localparam int FILT_W = 8;

endpackage

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, tick-sampled stability filter and auto-repeat FSM.
// Emits registered single-cycle press/release pulses alongside the debounced level.
module key_channel
   import key_pkg::*;
#(
   parameter int N_STABLE     = 5,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_RATE  = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic key_raw,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic              sync_q1;
   logic              sync_q2;
   logic [FILT_W-1:0] filt_q;
   logic [FILT_W-1:0] filt_d;
   logic [REP_W-1:0]  rep_q;
   logic [REP_W-1:0]  rep_d;
   rep_state_e        state_q;
   rep_state_e        state_d;
   logic              level_d;
   logic              press_evt;
   logic              release_evt;
   logic              rep_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the synchroniser resets to "released" so a key held through reset re-qualifies as a fresh press.
         sync_q1       <= 1'b0;
         sync_q2       <= 1'b0;
         filt_q        <= '0;
         rep_q         <= '0;
         state_q       <= RELEASED;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_q1       <= key_raw ^ ACTIVE_LOW;
         sync_q2       <= sync_q1;
         filt_q        <= filt_d;
         rep_q         <= rep_d;
         state_q       <= state_d;
         level         <= level_d;
         press         <= press_evt | rep_pulse;
         release_pulse <= release_evt;
      end
   end

   always_comb begin
      // NOTE: every next-value signal is defaulted first so no path through this block infers a latch.
      filt_d      = filt_q;
      rep_d       = rep_q;
      state_d     = state_q;
      level_d     = level;
      press_evt   = 1'b0;
      release_evt = 1'b0;
      rep_pulse   = 1'b0;

      if (tick) begin
         if (sync_q2 != level) begin
            if (int'(filt_q) + 1 == N_STABLE) begin
               filt_d      = '0;
               level_d     = ~level;
               press_evt   = ~level;
               release_evt = level;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end else begin
            filt_d = '0;
         end

         case (state_q)
            RELEASED: begin
               if (press_evt) begin
                  state_d = HELD_DELAY;
                  rep_d   = '0;
               end
            end
            HELD_DELAY: begin
               if (release_evt) begin
                  state_d = RELEASED;
               end else if (REPEAT_DELAY != 0) begin
                  if (int'(rep_q) + 1 == REPEAT_DELAY) begin
                     rep_pulse = 1'b1;
                     state_d   = HELD_REPEAT;
                     rep_d     = '0;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end
            end
            HELD_REPEAT: begin
               if (release_evt) begin
                  state_d = RELEASED;
               end else if (int'(rep_q) + 1 == REPEAT_RATE) begin
                  rep_pulse = 1'b1;
                  rep_d     = '0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
            default: state_d = RELEASED;
         endcase
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Raw push-buttons to clean command pulses: shared sample-tick prescaler plus
// one key_channel per key. O_PRESS feeds the SPI transfer controller's start input.
module key_conditioner
   import key_pkg::*;
#(
   parameter int N_KEYS       = 2,
   parameter int TICK_DIV     = TICK_DIV_27MHZ,
   parameter int N_STABLE     = 5,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter int REPEAT_DELAY = 0,
   parameter int REPEAT_RATE  = 100
) (
   input  logic              I_CLK,
   input  logic              I_RESET,
   input  logic [N_KEYS-1:0] I_KEY,
   output logic [N_KEYS-1:0] O_LEVEL,
   output logic [N_KEYS-1:0] O_PRESS,
   output logic [N_KEYS-1:0] O_RELEASE,
   output logic              O_TICK
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [DIV_W-1:0] div_q;
   logic             div_wrap;

   assign div_wrap = (int'(div_q) == TICK_DIV - 1);

   // With TICK_DIV=1 the counter sits at 0 and the tick is high every cycle.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         div_q  <= '0;
         O_TICK <= 1'b0;
      end else begin
         div_q  <= div_wrap ? '0 : div_q + 1'b1;
         O_TICK <= div_wrap;
      end
   end

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      key_channel #(
         .N_STABLE     (N_STABLE),
         .ACTIVE_LOW   (ACTIVE_LOW),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_channel (
         .clk           (I_CLK),
         .rst           (I_RESET),
         .tick          (O_TICK),
         .key_raw       (I_KEY[k]),
         .level         (O_LEVEL[k]),
         .press         (O_PRESS[k]),
         .release_pulse (O_RELEASE[k])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: two instances (auto-repeat on / off) driven by the same keys,
// compared every cycle against a tick-level behavioural model of the debounce and repeat rules.
module tb_key_conditioner;

   localparam int TD = 4;
   localparam int NS = 3;
   localparam int RD = 5;
   localparam int RR = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] key;
   logic [1:0] a_level, a_press, a_release;
   logic       a_tick;
   logic [1:0] b_level, b_press, b_release;
   logic       b_tick;

   always #5 clk = ~clk;

   key_conditioner #(
      .N_KEYS(2), .TICK_DIV(TD), .N_STABLE(NS), .ACTIVE_LOW(1'b1),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) u_dut_a (
      .I_CLK(clk), .I_RESET(rst), .I_KEY(key),
      .O_LEVEL(a_level), .O_PRESS(a_press), .O_RELEASE(a_release), .O_TICK(a_tick)
   );

   key_conditioner #(
      .N_KEYS(2), .TICK_DIV(TD), .N_STABLE(NS), .ACTIVE_LOW(1'b1),
      .REPEAT_DELAY(0), .REPEAT_RATE(RR)
   ) u_dut_b (
      .I_CLK(clk), .I_RESET(rst), .I_KEY(key),
      .O_LEVEL(b_level), .O_PRESS(b_press), .O_RELEASE(b_release), .O_TICK(b_tick)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: cycles since reset, pressed samples from the last two edges, and per key the
   // debounced level, the run of samples disagreeing with it, and ticks held since the press.
   int         cyc;
   logic [1:0] d1, d2;
   logic [1:0] m_level;
   int         run  [2];
   int         held [2];
   logic [1:0] e_press_a, e_press_b, e_rel;
   logic       e_tick;

   function automatic logic [6:0] a_obs();
      return {a_level, a_press, a_release, a_tick};
   endfunction
   function automatic logic [6:0] a_exp();
      return {m_level, e_press_a, e_rel, e_tick};
   endfunction
   function automatic logic [6:0] b_obs();
      return {b_level, b_press, b_release, b_tick};
   endfunction
   function automatic logic [6:0] b_exp();
      return {m_level, e_press_b, e_rel, e_tick};
   endfunction

   // Advance one clock edge and update the model with the inputs the DUT sampled there.
   task automatic step();
      logic [1:0] pressed;
      logic [1:0] s_used;
      logic       r;
      bit         evt;
      pressed = ~key;
      r       = rst;
      @(posedge clk);
      if (r) begin
         cyc = 0; d1 = '0; d2 = '0; m_level = '0;
         run = '{0, 0}; held = '{0, 0};
         e_press_a = '0; e_press_b = '0; e_rel = '0; e_tick = 1'b0;
      end else begin
         cyc++;
         s_used = d2; d2 = d1; d1 = pressed;
         e_press_a = '0; e_press_b = '0; e_rel = '0;
         e_tick = (cyc % TD == 0);
         if (cyc - 1 >= 1 && (cyc - 1) % TD == 0) begin
            for (int k = 0; k < 2; k++) begin
               evt = 1'b0;
               if (s_used[k] != m_level[k]) begin
                  run[k]++;
                  if (run[k] == NS) begin
                     run[k]     = 0;
                     m_level[k] = ~m_level[k];
                     evt        = 1'b1;
                     if (m_level[k]) begin
                        e_press_a[k] = 1'b1;
                        e_press_b[k] = 1'b1;
                        held[k]      = 0;
                     end else begin
                        e_rel[k] = 1'b1;
                     end
                  end
               end else begin
                  run[k] = 0;
               end
               if (!evt && m_level[k]) begin
                  held[k]++;
                  if (held[k] >= RD && (held[k] - RD) % RR == 0) e_press_a[k] = 1'b1;
               end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key = 2'b11;
      step();
      step();
      n_checks++;
      if (a_obs() !== 7'b0) begin
         n_errors++; $display("FAIL reset_a got %b want %b", a_obs(), 7'b0);
      end
      n_checks++;
      if (b_obs() !== 7'b0) begin
         n_errors++; $display("FAIL reset_b got %b want %b", b_obs(), 7'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < 2 * TD; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL reset_idle cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
      end
   endtask

   task automatic test_clean_press();
      int lat, n_press, n_rel;
      lat = -1; n_press = 0; n_rel = 0;
      repeat ($urandom_range(0, TD - 1)) step();
      key[0] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL clean_press cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         if (a_press[0]) begin
            n_press++;
            if (lat < 0) begin
               lat = i;
               n_checks++;
               if (a_level[0] !== 1'b1) begin
                  n_errors++; $display("FAIL clean_press_level got %b want 1", a_level[0]);
               end
            end
         end
         n_rel += int'(a_release[0]);
      end
      n_checks++;
      if (lat < 1 || lat > 2 + TD * NS + 1) begin
         n_errors++; $display("FAIL clean_press_latency got %0d want 1..%0d", lat, 2 + TD * NS + 1);
      end
      n_checks++;
      if (n_press != 1 || n_rel != 0) begin
         n_errors++; $display("FAIL clean_press_count got press %0d release %0d want 1 0", n_press, n_rel);
      end
      key[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL clean_release cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
      end
   endtask

   task automatic test_glitch();
      int len, pulses, n_press, n_rel;
      repeat (4) begin
         len    = $urandom_range(1, 2 * TD);
         pulses = 0;
         key[0] = 1'b0;
         for (int i = 0; i < len + 20; i++) begin
            if (i == len) key[0] = 1'b1;
            step();
            n_checks++;
            if (a_obs() !== a_exp()) begin
               n_errors++; $display("FAIL glitch cyc %0d got %b want %b", cyc, a_obs(), a_exp());
            end
            pulses += int'(a_press[0]) + int'(a_release[0]);
         end
         n_checks++;
         if (pulses != 0 || a_level[0] !== 1'b0) begin
            n_errors++; $display("FAIL glitch_reject len %0d got pulses %0d level %b want 0 0", len, pulses, a_level[0]);
         end
         repeat ($urandom_range(0, TD - 1)) step();
      end
      n_press = 0; n_rel = 0;
      key[0] = 1'b0;
      for (int i = 0; i < NS * TD + 40; i++) begin
         if (i == NS * TD) key[0] = 1'b1;
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL glitch_hold cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         n_press += int'(a_press[0]);
         n_rel   += int'(a_release[0]);
      end
      n_checks++;
      if (n_press != 1 || n_rel != 1) begin
         n_errors++; $display("FAIL glitch_hold_count got press %0d release %0d want 1 1", n_press, n_rel);
      end
   endtask

   task automatic test_auto_repeat();
      localparam int HOLD_TICKS = 20;
      int pt[$];
      int rel_at, n_rel, want;
      rel_at = -1; n_rel = 0;
      repeat ($urandom_range(0, TD - 1)) step();
      key[1] = 1'b0;
      for (int i = 0; i < HOLD_TICKS * TD + 40; i++) begin
         if (i == HOLD_TICKS * TD) key[1] = 1'b1;
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL auto_repeat cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         if (a_press[1]) pt.push_back(i);
         if (a_release[1]) begin
            n_rel++;
            rel_at = i;
         end
      end
      // press, then repeats at held ticks RD, RD+RR, ... up to HOLD_TICKS-1
      want = 1 + (HOLD_TICKS - 1 - RD) / RR + 1;
      n_checks++;
      if (pt.size() != want || n_rel != 1) begin
         n_errors++; $display("FAIL auto_repeat_count got press %0d release %0d want %0d 1", pt.size(), n_rel, want);
      end
      if (pt.size() >= 2) begin
         n_checks++;
         if (pt[1] - pt[0] != RD * TD) begin
            n_errors++; $display("FAIL auto_repeat_delay got %0d want %0d", pt[1] - pt[0], RD * TD);
         end
         for (int i = 2; i < pt.size(); i++) begin
            n_checks++;
            if (pt[i] - pt[i-1] != RR * TD) begin
               n_errors++; $display("FAIL auto_repeat_rate got %0d want %0d", pt[i] - pt[i-1], RR * TD);
            end
         end
         n_checks++;
         if (pt[pt.size() - 1] >= rel_at) begin
            n_errors++; $display("FAIL auto_repeat_after_release got press at %0d release at %0d", pt[pt.size() - 1], rel_at);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit both, split;
      both = 1'b0; split = 1'b0;
      repeat ($urandom_range(0, TD - 1)) step();
      key = 2'b00;
      for (int i = 0; i < 50; i++) begin
         if (i == 16) key = 2'b11;
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL simultaneous cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         if (a_press == 2'b11) both = 1'b1;
         if (a_press == 2'b01 || a_press == 2'b10) split = 1'b1;
      end
      n_checks++;
      if (!both || split) begin
         n_errors++; $display("FAIL simultaneous_pair got both %b split %b want 1 0", both, split);
      end
   endtask

   task automatic test_reset_mid();
      int presses, t_tick, t_press;
      presses = 0; t_tick = -1; t_press = -1;
      key[0] = 1'b0;
      for (int i = 0; i < 80 && presses < 2; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL reset_mid_pre cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         presses += int'(a_press[0]);
      end
      n_checks++;
      if (presses < 2) begin
         n_errors++; $display("FAIL reset_mid_wait got %0d presses want 2 within 80 cycles", presses);
      end
      repeat ($urandom_range(1, 2 * TD)) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (a_obs() !== 7'b0) begin
         n_errors++; $display("FAIL reset_mid_clear_a got %b want %b", a_obs(), 7'b0);
      end
      n_checks++;
      if (b_obs() !== 7'b0) begin
         n_errors++; $display("FAIL reset_mid_clear_b got %b want %b", b_obs(), 7'b0);
      end
      for (int i = 1; i <= NS * TD + 4; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL reset_mid_post cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         if (a_tick && t_tick < 0) t_tick = i;
         if (a_press[0] && t_press < 0) t_press = i;
      end
      n_checks++;
      if (t_tick != TD) begin
         n_errors++; $display("FAIL reset_mid_tick got %0d want %0d", t_tick, TD);
      end
      n_checks++;
      if (t_press != NS * TD + 1) begin
         n_errors++; $display("FAIL reset_mid_repress got %0d want %0d", t_press, NS * TD + 1);
      end
      key[0] = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL reset_mid_release cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
      end
   endtask

   task automatic test_no_repeat();
      int n_press, n_rel;
      n_press = 0; n_rel = 0;
      key[0] = 1'b0;
      for (int i = 0; i < 50 * TD + 40; i++) begin
         if (i == 50 * TD) key[0] = 1'b1;
         step();
         n_checks++;
         if (b_obs() !== b_exp()) begin
            n_errors++; $display("FAIL no_repeat_b cyc %0d got %b want %b", cyc, b_obs(), b_exp());
         end
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL no_repeat_a cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         n_press += int'(b_press[0]);
         n_rel   += int'(b_release[0]);
      end
      n_checks++;
      if (n_press != 1 || n_rel != 1) begin
         n_errors++; $display("FAIL no_repeat_count got press %0d release %0d want 1 1", n_press, n_rel);
      end
   endtask

   task automatic test_random();
      int left [2];
      left = '{$urandom_range(1, 40), $urandom_range(1, 40)};
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < 2; k++) begin
            left[k]--;
            if (left[k] == 0) begin
               key[k]  = ~key[k];
               left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 120) : $urandom_range(1, 16);
            end
         end
         step();
         n_checks++;
         if (a_obs() !== a_exp()) begin
            n_errors++; $display("FAIL random_a cyc %0d got %b want %b", cyc, a_obs(), a_exp());
         end
         n_checks++;
         if (b_obs() !== b_exp()) begin
            n_errors++; $display("FAIL random_b cyc %0d got %b want %b", cyc, b_obs(), b_exp());
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      key = 2'b11;
      test_reset();
      test_clean_press();
      test_glitch();
      test_auto_repeat();
      test_simultaneous();
      test_reset_mid();
      test_no_repeat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
